// File: rtl/sb_pkg.sv
// Shared definitions for the register scoreboard: register address width,
// default register count, pending-counter width and the register index type.
package sb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_pending_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
// Increment is refused when full, decrement is refused when empty, so the
// count never wraps in either direction. A simultaneous increment and
// decrement that both take effect leave the count unchanged.
// When SCOREBOARD_WB_BYPASS_EN is defined an extra 'one' flag reports
// count == 1 so the top level can forward a retiring write.
module sb_pending_cnt #(
    parameter int CNT_W = sb_pkg::CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
`ifdef SCOREBOARD_WB_BYPASS_EN
    output logic one,
`endif
    output logic zero,
    output logic full
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;
    logic             do_inc;
    logic             do_dec;

    assign do_inc = inc && !full;
    assign do_dec = dec && !zero;

    // Pending count: +1 on accepted issue, -1 on accepted writeback.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (do_inc && !do_dec) begin
            count <= count + CNT_W'(1);
        end else if (do_dec && !do_inc) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign full = (count == CNT_MAX);
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign one  = (count == CNT_W'(1));
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for an in-order pipeline. Tracks outstanding writes per
// architectural register, stalls decode while a source operand is pending and
// refuses an issue that would overflow the destination's pending counter.
// Register 0 is hard-wired idle.
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to let a source whose
// last pending write retires in the current cycle proceed without stalling.
module reg_scoreboard #(
    parameter int NUM_REGS = sb_pkg::NUM_REGS,
    parameter int CNT_W    = sb_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_reg_write,
    input  sb_pkg::reg_addr_t   issue_rd,
    input  sb_pkg::reg_addr_t   rs1_id,
    input  sb_pkg::reg_addr_t   rs2_id,
    input  logic                wb_valid,
    input  sb_pkg::reg_addr_t   wb_rd,
    output logic                stall,
    output logic                issue_ready,
    output logic [NUM_REGS-1:0] busy
);

    import sb_pkg::*;

    logic [NUM_REGS-1:0] zero_f;
    logic [NUM_REGS-1:0] full_f;
`ifdef SCOREBOARD_WB_BYPASS_EN
    logic [NUM_REGS-1:0] one_f;
`endif
    logic issue_fire;
    logic wb_fire;
    logic rs1_wait;
    logic rs2_wait;

    // Only an instruction that actually leaves decode may claim a counter.
    assign issue_fire = issue_valid && issue_reg_write && (issue_rd != '0) && !stall;
    assign wb_fire    = wb_valid && (wb_rd != '0);

    // Register 0 has no counter: permanently empty, never full.
    assign zero_f[0] = 1'b1;
    assign full_f[0] = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign one_f[0]  = 1'b0;
`endif

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_pending_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (issue_fire && (issue_rd == reg_addr_t'(i))),
            .dec   (wb_fire && (wb_rd == reg_addr_t'(i))),
`ifdef SCOREBOARD_WB_BYPASS_EN
            .one   (one_f[i]),
`endif
            .zero  (zero_f[i]),
            .full  (full_f[i])
        );
    end

    assign busy        = ~zero_f;
    assign issue_ready = !(issue_reg_write && full_f[issue_rd]);

    // Decode hold: a nonzero source still has a pending write, or the destination counter is saturated.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rs1_wait = (rs1_id != '0) && busy[rs1_id];
        rs2_wait = (rs2_id != '0) && busy[rs2_id];
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && (wb_rd == rs1_id) && one_f[rs1_id]) rs1_wait = 1'b0;
        if (wb_valid && (wb_rd == rs2_id) && one_f[rs2_id]) rs2_wait = 1'b0;
`endif
        stall = rs1_wait || rs2_wait || !issue_ready;
    end

endmodule
